sram1024x18_port_ctrl: RTL and testbench
========================================

// Module: sram1024x18_port_ctrl
// PURPOSE
//  Request/response front-end for one port (A or B) of the 1024x18 dual-port SRAM macro.
//  Converts a valid/ready request stream into the macro's active-low cen/wen/wmsk port signals.
//  Captures read data one cycle after issue into a credit-protected response FIFO.
//  Optionally zero-fills the array after reset before accepting traffic.
// PARAMETERS
//  ADDR_W          10  address width (1024 words)
//  DATA_W          18  word width
//  BYTE_W          9   byte-lane width; DATA_W/BYTE_W = 2 lanes
//  RSP_DEPTH       2   response FIFO entries (>=2)
//  CLEAR_ON_RESET  1   1: write 0 to every address after reset; 0: go straight to RUN
// PORTS
//  clk         in   1       clock; also drives the macro's clk_a/clk_b
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       request valid
//  req_ready   out  1       request accepted when valid & ready at posedge
//  req_we      in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  word address
//  req_be      in   2       byte enables; be[0] = bits 8:0, be[1] = bits 17:9
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       read response valid
//  rsp_ready   in   1       response consumed when valid & ready at posedge
//  rsp_rdata   out  DATA_W  read data
//  init_done   out  1       1 once in RUN
//  sram_cen    out  1       to cen_x; active low
//  sram_wen    out  1       to wen_x; active low
//  sram_addr   out  ADDR_W  to addr_x
//  sram_wmsk   out  DATA_W  to wmsk_x; 1 = keep bit
//  sram_wdata  out  DATA_W  to wdata_x
//  sram_rdata  in   DATA_W  from rdata_x
// BEHAVIOUR
//  - Reset values (async, rst_n=0):
//    - FSM state: CLEAR if CLEAR_ON_RESET, else RUN.
//    - FIFO is empty; rd_pend = 0; clear counter = 0.
//    - Outputs: req_ready=0 while CLEAR, rsp_valid=0, rsp_rdata=0, init_done=0 while CLEAR.
//    - SRAM outputs: sram_cen=1, sram_wen=1, sram_wmsk='1, sram_addr=0, sram_wdata=0.
//  - FSM CLEAR:
//    - Drives cen=0, wen=0, wmsk=0, wdata=0, addr=counter; counter increments every cycle.
//    - At counter==1023, moves to RUN. CLEAR therefore lasts exactly 1024 cycles.
//    - req_ready=0 throughout CLEAR.
//  - FSM RUN: terminal state; init_done=1.
//  - Accept (RUN):
//    - req_ready = req_we | (fifo_count + rd_pend < RSP_DEPTH).
//    - req_ready never depends on req_valid.
//  - Issue (combinational from the request):
//    - Accept drives cen=0, addr=req_addr, wen=~req_we.
//    - Write: wmsk = ~{{9{be[1]}},{9{be[0]}}}, wdata=req_wdata.
//    - Read: wmsk='1.
//    - No accept: cen=1, wen=1, wmsk='1.
//  - Read latency:
//    - Read accepted at edge N sets rd_pend; sram_rdata is sampled and pushed at edge N+1.
//    - rsp_valid rises after edge N+1, i.e. 1 cycle after acceptance, when the FIFO was empty.
//  - Writes produce no response. Responses return in issue order.
//  - Write-first: a read issued the cycle after a write to the same address returns the new data.
//  - FIFO:
//    - Simultaneous push and pop keeps the count unchanged.
//    - Overflow cannot occur because of the accept credit.
//    - rsp_rdata holds while rsp_valid & ~rsp_ready.
//  - Reset mid-operation:
//    - Pending reads and FIFO contents are discarded; no response is emitted.
//    - CLEAR restarts from address 0.
// STRUCTURE
//  - sram_ctrl_pkg holds ADDR_W/DATA_W/BYTE_W defaults, the state enum {CLEAR, RUN} and the lane-count constant.
//  - Sub-module sram_rsp_fifo (DEPTH, WIDTH): circular buffer with push/pop, count, async reset.
//  - Top level holds the FSM, the clear counter, rd_pend, credit logic and port encoding.
// TESTING
//  1. CLEAR_ON_RESET=1, release rst_n -> sram_cen=0/wen=0 for 1024 cycles, addr 0..1023; init_done=1 after; then read addr 1023 -> 0x00000.
//  2. Write addr 5 data 0x3FFFF be=2'b11, then read addr 5 -> rsp_rdata=0x3FFFF, rsp_valid 1 cycle after read accept.
//  3. Write addr 5 data 0x00155 be=2'b01 over 0x3FFFF, read -> 0x3FF55; sram_wmsk observed = 0x3FE00.
//  4. rsp_ready=0, issue 3 back-to-back reads -> 2 accepted, req_ready=0; writes still accepted; raise rsp_ready -> in-order data, then 3rd read accepted.
//  5. Write 0x2AAAA addr 7 then read addr 7 on the next cycle -> 0x2AAAA.
//  6. Assert rst_n=0 mid-CLEAR (addr ~300) and with 1 read pending -> all outputs at reset values immediately, no rsp_valid, CLEAR restarts at addr 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, lane constants and FSM state type for the SRAM port controller.
package sram_ctrl_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned BYTE_W = 9;
  localparam int unsigned LANES  = DATA_W / BYTE_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small circular response buffer; head is always visible, count tracks occupancy.
module sram_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 18
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage, pointers and occupancy; pointers wrap explicitly so any DEPTH works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sram1024x18_port_ctrl.sv
// Valid/ready front-end for one port of the 1024x18 dual-port SRAM macro.
module sram1024x18_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned RSP_DEPTH      = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LANES-1:0]  req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wmsk,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam state_e      RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rd_pend;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic              accept;
  logic              rsp_pop;
  logic [DATA_W-1:0] wmsk_wr;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear address counter and the one-cycle read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
      rd_pend <= accept & ~req_we;
    end
  end

  // Expand per-lane byte enables into the macro's keep-bit mask.
  always_comb begin
    wmsk_wr = '1;
    for (int l = 0; l < int'(LANES); l++) begin
      wmsk_wr[l*BYTE_W +: BYTE_W] = {BYTE_W{~req_be[l]}};
    end
  end

  // Reads in flight plus buffered responses must leave room for one more read.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(rd_pend);
  assign credit_ok = occupancy < (CNT_W+1)'(RSP_DEPTH);
  assign accept    = req_valid & req_ready;

  // Next state, handshake and macro port encoding; idle encoding while in reset.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    init_done  = 1'b0;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_wmsk  = '1;
    sram_addr  = '0;
    sram_wdata = '0;
    if (rst_n) begin
      case (state)
        CLEAR: begin
          sram_cen  = 1'b0;
          sram_wen  = 1'b0;
          sram_wmsk = '0;
          sram_addr = clr_cnt;
          if (clr_cnt == '1) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          init_done = 1'b1;
          req_ready = req_we | credit_ok;
          if (req_valid && (req_we || credit_ok)) begin
            sram_cen  = 1'b0;
            sram_wen  = ~req_we;
            sram_addr = req_addr;
            if (req_we) begin
              sram_wmsk  = wmsk_wr;
              sram_wdata = req_wdata;
            end
          end
        end
        default: state_nxt = RST_STATE;
      endcase
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_pop   = rsp_valid & rsp_ready;

  // Read data arrives one cycle after issue and is queued in issue order.
  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend),
    .push_data (sram_rdata),
    .pop       (rsp_pop),
    .head      (rsp_rdata),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram1024x18_port_ctrl.sv
// Directed bench for the SRAM port controller with a behavioural macro port model.
module tb_sram1024x18_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [1:0]  req_be;
  logic [17:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [17:0] rsp_rdata;
  logic        init_done;
  logic        sram_cen;
  logic        sram_wen;
  logic [9:0]  sram_addr;
  logic [17:0] sram_wmsk;
  logic [17:0] sram_wdata;
  logic [17:0] sram_rdata = '0;

  logic [17:0] mem [1024];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram1024x18_port_ctrl #(
    .RSP_DEPTH      (2),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wmsk  (sram_wmsk),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Macro port model: masked synchronous write, registered read data.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 18'($urandom);
  end

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= (mem[sram_addr] & sram_wmsk) | (sram_wdata & ~sram_wmsk);
      else           sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cen"},   64'(sram_cen),   64'd1);
    check({tag, "_wen"},   64'(sram_wen),   64'd1);
    check({tag, "_wmsk"},  64'(sram_wmsk),  64'h3FFFF);
    check({tag, "_addr"},  64'(sram_addr),  64'd0);
    check({tag, "_wdata"}, 64'(sram_wdata), 64'd0);
    check({tag, "_rdy"},   64'(req_ready),  64'd0);
    check({tag, "_init"},  64'(init_done),  64'd0);
    check({tag, "_rvld"},  64'(rsp_valid),  64'd0);
    check({tag, "_rdata"}, 64'(rsp_rdata),  64'd0);
  endtask

  // Called #1 after a posedge with CLEAR counter at 0; checks n clear cycles.
  task automatic run_clear(input int n, input string tag);
    logic [63:0] obs;
    logic [63:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = {13'd0, sram_cen, sram_wen, sram_addr, sram_wmsk, sram_wdata, req_ready, init_done, rsp_valid};
      exp = {13'd0, 2'b00, 10'(i), 36'd0, 3'b000};
      check(tag, obs, exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [17:0] d, input logic [1:0] be,
                          input logic [17:0] exp_wmsk, input string tag);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
    check({tag, "_rdy"},  64'(req_ready), 64'd1);
    check({tag, "_port"}, {44'd0, sram_cen, sram_wen, sram_addr, 8'd0}, {44'd0, 2'b00, a, 8'd0});
    check({tag, "_wmsk"}, 64'(sram_wmsk), 64'(exp_wmsk));
    check({tag, "_wd"},   64'(sram_wdata), 64'(d));
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic read_expect(input logic [9:0] a, input logic [17:0] exp, input string tag);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    check({tag, "_rdy"},  64'(req_ready), 64'd1);
    check({tag, "_port"}, {44'd0, sram_cen, sram_wen, sram_addr, sram_wmsk[7:0]},
                          {44'd0, 2'b01, a, 8'hFF});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_vld0"}, 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_vld1"}, 64'(rsp_valid), 64'd1);
    check({tag, "_data"}, 64'(rsp_rdata), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_popped"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");

    // 1. Zero-fill after reset release, then read back the last address.
    rst_n = 1'b1;
    run_clear(1024, "clear");
    check("init_done", 64'(init_done), 64'd1);
    read_expect(10'd1023, 18'h00000, "rd1023");

    // 2. Full write then read.
    do_write(10'd5, 18'h3FFFF, 2'b11, 18'h00000, "wr5_full");
    read_expect(10'd5, 18'h3FFFF, "rd5_full");

    // 3. Low lane only.
    do_write(10'd5, 18'h00155, 2'b01, 18'h3FE00, "wr5_lo");
    read_expect(10'd5, 18'h3FF55, "rd5_lo");

    // 5. Read immediately after a write to the same address.
    do_write(10'd7, 18'h2AAAA, 2'b11, 18'h00000, "wr7");
    read_expect(10'd7, 18'h2AAAA, "rd7_b2b");

    // 4. Back-pressure: two reads consume the credit, third stalls.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    @(negedge clk); check("bp_rd1_rdy", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_addr = 10'd7;
    @(negedge clk); check("bp_rd2_rdy", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_addr = 10'd1023;
    @(negedge clk);
    check("bp_rd3_stall", 64'(req_ready), 64'd0);
    check("bp_rd3_cen",   64'(sram_cen),  64'd1);
    @(posedge clk); #1;
    check("bp_full_rdy",  64'(req_ready), 64'd0);
    check("bp_full_vld",  64'(rsp_valid), 64'd1);
    check("bp_head_hold", 64'(rsp_rdata), 64'h3FF55);
    req_valid = 1'b0;
    do_write(10'd9, 18'h12345, 2'b11, 18'h00000, "bp_wr9");
    check("bp_head_hold2", 64'(rsp_rdata), 64'h3FF55);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd1023; rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_rd3_still", 64'(req_ready), 64'd0);
    check("bp_first",     64'(rsp_rdata), 64'h3FF55);
    @(posedge clk); #1;
    check("bp_second_vld", 64'(rsp_valid), 64'd1);
    check("bp_second",     64'(rsp_rdata), 64'h2AAAA);
    @(negedge clk);
    check("bp_rd3_rdy", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_drained", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("bp_third_vld", 64'(rsp_valid), 64'd1);
    check("bp_third",     64'(rsp_rdata), 64'h00000);
    @(posedge clk); #1;
    check("bp_empty", 64'(rsp_valid), 64'd0);
    read_expect(10'd9, 18'h12345, "rd9");

    // 6. Reset with a read in flight, then reset again mid-clear.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("rst_pend");
    repeat (2) @(posedge clk);
    #1;
    check("rst_pend_novld", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    run_clear(300, "clear_a");
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_clear(1024, "clear_b");
    check("init_done2", 64'(init_done), 64'd1);
    read_expect(10'd5, 18'h00000, "rd5_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
